// File: rtl/sd_sync_pkg.sv
// Shared constants and helpers for the input synchroniser / debounce block.
package sd_sync_pkg;

   localparam int unsigned SYNC_STAGES_MIN = 2;

   // Counter width for a debounce window of `cycles`; always at least one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/sd_input_debounce_ch.sv
// One channel: flop synchroniser chain, stability counter, registered level and edge strobes.
module sd_input_debounce_ch
   import sd_sync_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic        RESET_VALUE     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_in,
   input  logic i_filter_en,
   output logic o_out,
   output logic o_rise,
   output logic o_fall,
   output logic o_strobe_next
);

   localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_out;
   logic             r_rise;
   logic             r_fall;
   logic             w_out_d;
   logic             w_rise_d;
   logic             w_fall_d;
   logic             w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_VALUE}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      end
   end

   // Counter is cleared on match, on terminal count and whenever filtering is off.
   always_comb begin
      w_cnt_d = '0;
      w_out_d = r_out;
      if (!i_filter_en) begin
         w_out_d = w_sync;
      end else if (w_sync != r_out) begin
         if (r_cnt == CNT_MAX) begin
            w_out_d = w_sync;
         end else begin
            w_cnt_d = r_cnt + 1'b1;
         end
      end
      w_rise_d = w_out_d & ~r_out;
      w_fall_d = ~w_out_d & r_out;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_out  <= RESET_VALUE;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_d;
         r_out  <= w_out_d;
         r_rise <= w_rise_d;
         r_fall <= w_fall_d;
      end
   end

   assign o_out         = r_out;
   assign o_rise        = r_rise;
   assign o_fall        = r_fall;
   assign o_strobe_next = w_rise_d | w_fall_d;

endmodule

// File: rtl/sd_input_debounce_sync.sv
// Multi-channel synchroniser with optional debounce; clean levels plus rise/fall/changed strobes.
module sd_input_debounce_sync
   import sd_sync_pkg::*;
#(
   parameter int unsigned      WIDTH           = 2,
   parameter int unsigned      SYNC_STAGES     = 2,
   parameter int unsigned      DEBOUNCE_CYCLES = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_in,
   input  logic             i_filter_en,
   output logic [WIDTH-1:0] o_out,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic             o_changed
);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_chk_sync
      $fatal(1, "SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
      $fatal(1, "DEBOUNCE_CYCLES must be at least 1");
   end

   logic [WIDTH-1:0] w_strobe_next;
   logic             r_changed;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sd_input_debounce_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_VALUE    (RESET_VALUE[i])
      ) u_ch (
         .i_clk        (i_clk),
         .i_rst_n      (i_rst_n),
         .i_in         (i_in[i]),
         .i_filter_en  (i_filter_en),
         .o_out        (o_out[i]),
         .o_rise       (o_rise[i]),
         .o_fall       (o_fall[i]),
         .o_strobe_next(w_strobe_next[i])
      );
   end

   // Built from next-state strobes so changed lines up with rise/fall.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_strobe_next;
      end
   end

   assign o_changed = r_changed;

endmodule

// File: tb/tb_sd_input_debounce_sync.sv
// Scoreboard bench: stimulus queues expected strobe events, a negedge monitor pops and compares.
module tb_sd_input_debounce_sync;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] in;
   logic       filter_en;
   logic [1:0] out;
   logic [1:0] rise;
   logic [1:0] fall;
   logic       changed;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      logic [1:0] out;
      logic [1:0] rise;
      logic [1:0] fall;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   sd_input_debounce_sync #(
      .WIDTH          (2),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .RESET_VALUE    (2'b00)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in       (in),
      .i_filter_en(filter_en),
      .o_out      (out),
      .o_rise     (rise),
      .o_fall     (fall),
      .o_changed  (changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input logic [1:0] o, input logic [1:0] r, input logic [1:0] f,
                            input int at);
      exp_t e;
      e.out  = o;
      e.rise = r;
      e.fall = f;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   // Any strobe activity must match the head of the queue, both in value and in cycle.
   always @(negedge clk) begin
      if ((rise | fall) != 2'b00 || changed) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: got rise=%b fall=%b changed=%b out=%b, none expected (cycle %0d)",
                     rise, fall, changed, out, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("strobe_cycle", cyc, mon_e.cyc);
            check("strobe_out", {30'd0, out}, {30'd0, mon_e.out});
            check("strobe_rise", {30'd0, rise}, {30'd0, mon_e.rise});
            check("strobe_fall", {30'd0, fall}, {30'd0, mon_e.fall});
            check("strobe_changed", {31'd0, changed}, 32'd1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      // 1: reset held with inputs high
      rst_n     = 1'b0;
      in        = 2'b11;
      filter_en = 1'b1;
      wait_cyc(10);
      check("reset_out", {30'd0, out}, 32'h0);
      check("reset_rise", {30'd0, rise}, 32'h0);
      check("reset_fall", {30'd0, fall}, 32'h0);
      check("reset_changed", {31'd0, changed}, 32'h0);
      in    = 2'b00;
      rst_n = 1'b1;
      wait_cyc(10);
      check("post_release_out", {30'd0, out}, 32'h0);

      // 3: 3-cycle pulse on ch0 is filtered out
      in = 2'b01;
      wait_cyc(3);
      in = 2'b00;
      wait_cyc(12);
      check("glitch_out", {30'd0, out}, 32'h0);

      // 2: both channels rise, update on edge 6
      c  = cyc;
      in = 2'b11;
      expect_ev(2'b11, 2'b11, 2'b00, c + 6);
      wait_cyc(5);
      check("rise_early_out", {30'd0, out}, 32'h0);
      wait_cyc(5);
      check("rise_out", {30'd0, out}, 32'h3);

      // 4: ch1 falls alone
      c  = cyc;
      in = 2'b01;
      expect_ev(2'b01, 2'b00, 2'b10, c + 6);
      wait_cyc(10);
      check("fall_out", {30'd0, out}, 32'h1);

      // 5: unfiltered, 3-edge latency, single-cycle glitch passes through
      filter_en = 1'b0;
      c  = cyc;
      in = 2'b00;
      expect_ev(2'b00, 2'b00, 2'b01, c + 3);
      wait_cyc(6);
      c  = cyc;
      in = 2'b01;
      expect_ev(2'b01, 2'b01, 2'b00, c + 3);
      wait_cyc(6);
      check("nofilt_out", {30'd0, out}, 32'h1);
      c  = cyc;
      in = 2'b00;
      expect_ev(2'b00, 2'b00, 2'b01, c + 3);
      expect_ev(2'b01, 2'b01, 2'b00, c + 4);
      wait_cyc(1);
      in = 2'b01;
      wait_cyc(8);
      check("nofilt_glitch_out", {30'd0, out}, 32'h1);

      // 6: async reset mid-debounce (cnt==2 after edge 4)
      filter_en = 1'b1;
      wait_cyc(4);
      in = 2'b00;
      wait_cyc(4);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out", {30'd0, out}, 32'h0);
      check("async_rst_rise", {30'd0, rise}, 32'h0);
      check("async_rst_fall", {30'd0, fall}, 32'h0);
      check("async_rst_changed", {31'd0, changed}, 32'h0);
      wait_cyc(3);
      in    = 2'b00;
      rst_n = 1'b1;
      wait_cyc(10);
      check("post_rst2_out", {30'd0, out}, 32'h0);

      wait_cyc(4);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
